// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Merges three writers into the single write port of a 32 x 32-bit register
// file. The writers are:
//   - the processor writeback (cpu_*), which is never stalled;
//   - an I/O updater (io_*), which uses a req/ack handshake and holds its
//     request stable until acknowledged;
//   - an internal scrub engine, which zeroes registers 1..31 after a
//     scrub_start pulse.
//
// Priority is cpu > starved io > scrub > io. The io requester becomes
// "starved" after IO_WAIT_MAX consecutive cycles of waiting, so a long
// scrub cannot lock it out.
//
// All outputs are registered. A request sampled at edge N appears on the
// outputs for exactly one cycle, starting at edge N+1. The scrub status
// outputs use the same one-cycle latency, so scrub_busy rises together with
// the first scrub write and scrub_done is high in the cycle after the
// register-31 write.
//
// Ports
//   clock            in   1   single clock, rising edge
//   ctrl_reset       in   1   synchronous reset, active low
//   cpu_we           in   1   processor write request (always granted)
//   cpu_reg          in   5   processor register index
//   cpu_data         in  32   processor write data
//   io_req           in   1   I/O write request, held until io_ack
//   io_reg           in   5   I/O register index
//   io_data          in  32   I/O write data
//   io_ack           out  1   one-cycle ack, coincident with the io write
//   scrub_start      in   1   pulse that starts zeroing registers 1..31
//   scrub_busy       out  1   scrub in progress
//   scrub_done       out  1   one-cycle scrub completion pulse
//   ctrl_writeEnable out  1   register file write enable
//   ctrl_writeReg    out  5   register file write index
//   data_writeReg    out 32   register file write data
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int IO_WAIT_MAX = 8
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_reg,
    input  logic [31:0] cpu_data,
    input  logic        io_req,
    input  logic [4:0]  io_reg,
    input  logic [31:0] io_data,
    output logic        io_ack,
    input  logic        scrub_start,
    output logic        scrub_busy,
    output logic        scrub_done,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg
);

    localparam int WAIT_W = (IO_WAIT_MAX < 1) ? 1 : $clog2(IO_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(IO_WAIT_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCRUB = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        ptr_q, ptr_d;
    logic [WAIT_W-1:0] io_wait_q, io_wait_d;

    logic              we_q, we_d;
    logic [4:0]        wreg_q, wreg_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              io_ack_q, io_ack_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              io_live;
    logic              io_starved;
    logic              grant_cpu;
    logic              grant_io;
    logic              grant_scrub;
    logic              grant_any;
    logic [4:0]        sel_reg;
    logic [31:0]       sel_data;

    always_comb begin
        // A request still high while its ack is on the outputs was already
        // served at the previous edge; it only counts again from the next one.
        io_live    = io_req && !io_ack_q;
        io_starved = io_live && (io_wait_q == WAIT_MAX);

        grant_cpu   = cpu_we;
        grant_io    = !cpu_we && (io_starved || (io_live && (state_q != S_SCRUB)));
        grant_scrub = !cpu_we && !io_starved && (state_q == S_SCRUB);
        grant_any   = grant_cpu || grant_io || grant_scrub;

        sel_reg  = 5'd0;
        sel_data = 32'd0;
        if (grant_cpu) begin
            sel_reg  = cpu_reg;
            sel_data = cpu_data;
        end else if (grant_io) begin
            sel_reg  = io_reg;
            sel_data = io_data;
        end else if (grant_scrub) begin
            sel_reg  = ptr_q;
            sel_data = 32'd0;
        end

        // Register 0 is hard-wired zero: the grant still consumes the slot
        // (and acks an io write) but the enable stays low.
        we_d     = grant_any && (sel_reg != 5'd0);
        wreg_d   = sel_reg;
        wdata_d  = sel_data;
        io_ack_d = grant_io;
        busy_d   = (state_q != S_IDLE);
        done_d   = (state_q == S_DONE);

        io_wait_d = io_wait_q;
        if (grant_io || !io_live) begin
            io_wait_d = '0;
        end else if (io_wait_q != WAIT_MAX) begin
            io_wait_d = io_wait_q + WAIT_W'(1);
        end

        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (scrub_start) begin
                    state_d = S_SCRUB;
                    ptr_d   = 5'd1;
                end
            end
            S_SCRUB: begin
                // ptr only moves on a cycle the scrub actually wrote, so a
                // lost slot never skips a register; 31 is terminal so ptr
                // never wraps back onto register 0.
                if (grant_scrub) begin
                    if (ptr_q == 5'd31) begin
                        state_d = S_DONE;
                        ptr_d   = 5'd1;
                    end else begin
                        ptr_d = ptr_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = 5'd1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= 5'd1;
            io_wait_q <= '0;
            we_q      <= 1'b0;
            wreg_q    <= 5'd0;
            wdata_q   <= 32'd0;
            io_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            io_wait_q <= io_wait_d;
            we_q      <= we_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            io_ack_q  <= io_ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;
    assign io_ack           = io_ack_q;
    assign scrub_busy       = busy_q;
    assign scrub_done       = done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Each step() drives one set of inputs, asks a small cycle model what the
// outputs must be after the next rising edge, queues that expectation, and
// after the edge pops and compares it against the DUT. Directed sections
// add explicit constant checks for the cpu path, cpu/io collision, register
// 0 suppression, a clean scrub, io starvation during a scrub and reset in
// the middle of a scrub; a random section then exercises the mix.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int IO_WAIT_MAX = 8;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        cpu_we;
    logic [4:0]  cpu_reg;
    logic [31:0] cpu_data;
    logic        io_req;
    logic [4:0]  io_reg;
    logic [31:0] io_data;
    logic        io_ack;
    logic        scrub_start;
    logic        scrub_busy;
    logic        scrub_done;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    always #5 clock = ~clock;

    regfile_write_arbiter #(.IO_WAIT_MAX(IO_WAIT_MAX)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .cpu_we           (cpu_we),
        .cpu_reg          (cpu_reg),
        .cpu_data         (cpu_data),
        .io_req           (io_req),
        .io_reg           (io_reg),
        .io_data          (io_data),
        .io_ack           (io_ack),
        .scrub_start      (scrub_start),
        .scrub_busy       (scrub_busy),
        .scrub_done       (scrub_done),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rg;
        logic [31:0] data;
        logic        ack;
        logic        busy;
        logic        done;
        logic        chk_data;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    bit verbose  = 1'b1;

    // model state: 0 idle, 1 scrub, 2 done
    int         m_state = 0;
    logic [4:0] m_ptr   = 5'd1;
    int         m_wait  = 0;
    logic       m_ack   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_push();
        exp_t        e;
        logic        live, starved, g_cpu, g_io, g_scr, any;
        logic [4:0]  r;
        logic [31:0] d;
        e.we = 1'b0; e.rg = 5'd0; e.data = 32'd0; e.ack = 1'b0;
        e.busy = 1'b0; e.done = 1'b0; e.chk_data = 1'b1;
        if (!ctrl_reset) begin
            m_state = 0;
            m_ptr   = 5'd1;
            m_wait  = 0;
            m_ack   = 1'b0;
        end else begin
            live    = io_req && !m_ack;
            starved = live && (m_wait == IO_WAIT_MAX);
            g_cpu   = cpu_we;
            g_io    = 1'b0;
            g_scr   = 1'b0;
            if (!g_cpu) begin
                if (starved)           g_io  = 1'b1;
                else if (m_state == 1) g_scr = 1'b1;
                else if (live)         g_io  = 1'b1;
            end
            r = 5'd0;
            d = 32'd0;
            if (g_cpu)      begin r = cpu_reg; d = cpu_data; end
            else if (g_io)  begin r = io_reg;  d = io_data;  end
            else if (g_scr) begin r = m_ptr;   d = 32'd0;    end
            any        = g_cpu || g_io || g_scr;
            e.we       = any && (r != 5'd0);
            e.rg       = r;
            e.data     = d;
            e.chk_data = !(any && (r == 5'd0));
            e.ack      = g_io;
            e.busy     = (m_state != 0);
            e.done     = (m_state == 2);
            if (g_io || !live)            m_wait = 0;
            else if (m_wait < IO_WAIT_MAX) m_wait = m_wait + 1;
            m_ack = g_io;
            case (m_state)
                0: if (scrub_start) begin m_state = 1; m_ptr = 5'd1; end
                1: if (g_scr) begin
                       if (m_ptr == 5'd31) begin m_state = 2; m_ptr = 5'd1; end
                       else m_ptr = m_ptr + 5'd1;
                   end
                default: m_state = 0;
            endcase
        end
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_push();
        @(posedge clock);
        @(negedge clock);
        chk("sb_has_entry", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_we",   ctrl_writeEnable, e.we);
            chk("sb_reg",  ctrl_writeReg,    e.rg);
            if (e.chk_data) chk("sb_data", data_writeReg, e.data);
            chk("sb_ack",  io_ack,     e.ack);
            chk("sb_busy", scrub_busy, e.busy);
            chk("sb_done", scrub_done, e.done);
        end
        if (verbose && (ctrl_writeEnable || io_ack))
            $display("t=%0t write we=%0b reg=%0d data=%h ack=%0b busy=%0b",
                     $time, ctrl_writeEnable, ctrl_writeReg, data_writeReg, io_ack, scrub_busy);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nxt;
        int k;
        bit found;

        ctrl_reset = 1'b0; cpu_we = 1'b0; cpu_reg = 5'd0; cpu_data = 32'd0;
        io_req = 1'b0; io_reg = 5'd0; io_data = 32'd0; scrub_start = 1'b0;
        @(negedge clock);

        // reset state
        step();
        step();
        chk("rst_we",   ctrl_writeEnable, 0);
        chk("rst_reg",  ctrl_writeReg,    0);
        chk("rst_data", data_writeReg,    0);
        chk("rst_ack",  io_ack,           0);
        chk("rst_busy", scrub_busy,       0);
        chk("rst_done", scrub_done,       0);
        ctrl_reset = 1'b1;
        step();

        // cpu path: one-cycle write, then idle
        cpu_we = 1'b1; cpu_reg = 5'd5; cpu_data = 32'hDEADBEEF;
        step();
        chk("cpu_we",   ctrl_writeEnable, 1);
        chk("cpu_reg",  ctrl_writeReg,    5);
        chk("cpu_data", data_writeReg,    32'hDEADBEEF);
        cpu_we = 1'b0; cpu_reg = 5'd0; cpu_data = 32'd0;
        step();
        chk("cpu_one_cycle", ctrl_writeEnable, 0);

        // cpu/io collision: cpu first, io one cycle later
        cpu_we = 1'b1; cpu_reg = 5'd3; cpu_data = 32'h3333_0003;
        io_req = 1'b1; io_reg = 5'd7; io_data = 32'h7777_0007;
        step();
        chk("coll_cpu_reg", ctrl_writeReg, 3);
        chk("coll_cpu_ack", io_ack,        0);
        cpu_we = 1'b0;
        step();
        chk("coll_io_reg",  ctrl_writeReg,    7);
        chk("coll_io_we",   ctrl_writeEnable, 1);
        chk("coll_io_ack",  io_ack,           1);
        chk("coll_io_data", data_writeReg,    32'h7777_0007);
        io_req = 1'b0;
        step();

        // register 0 suppression
        io_req = 1'b1; io_reg = 5'd0; io_data = 32'h1234_5678;
        step();
        chk("r0_ack", io_ack,           1);
        chk("r0_we",  ctrl_writeEnable, 0);
        chk("r0_reg", ctrl_writeReg,    0);
        io_req = 1'b0;
        step();

        // clean scrub
        scrub_start = 1'b1;
        step();
        scrub_start = 1'b0;
        nxt = 1;
        for (int i = 0; i < 31; i++) begin
            step();
            chk("scrub_we",   ctrl_writeEnable, 1);
            chk("scrub_reg",  ctrl_writeReg,    nxt);
            chk("scrub_data", data_writeReg,    0);
            nxt++;
        end
        step();
        chk("scrub_done_pulse", scrub_done,       1);
        chk("scrub_done_we",    ctrl_writeEnable, 0);
        step();
        chk("scrub_idle_busy",  scrub_busy, 0);
        chk("scrub_idle_done",  scrub_done, 0);

        // io starvation during a scrub
        scrub_start = 1'b1;
        step();
        scrub_start = 1'b0;
        io_req = 1'b1; io_reg = 5'd9; io_data = 32'hA5A5_A5A5;
        nxt = 1;
        k = 0;
        found = 1'b0;
        for (int i = 1; i <= 60 && nxt <= 31; i++) begin
            step();
            if (io_ack && !found) begin
                found = 1'b1;
                k = i;
                chk("starve_reg", ctrl_writeReg, 9);
                io_req = 1'b0;
            end else if (ctrl_writeEnable) begin
                chk("starve_scrub_reg", ctrl_writeReg, nxt);
                nxt++;
            end
        end
        chk("starve_ack_cycle",   k,   9);
        chk("starve_scrub_count", nxt, 32);
        step();
        chk("starve_done", scrub_done, 1);
        step();

        // reset in the middle of a scrub (ptr = 12 once reg 11 is written)
        scrub_start = 1'b1;
        step();
        scrub_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (ctrl_writeEnable && ctrl_writeReg == 5'd11) found = 1'b1;
        end
        chk("midrst_reached_11", found, 1);
        ctrl_reset = 1'b0;
        step();
        chk("midrst_we",   ctrl_writeEnable, 0);
        chk("midrst_reg",  ctrl_writeReg,    0);
        chk("midrst_data", data_writeReg,    0);
        chk("midrst_busy", scrub_busy,       0);
        ctrl_reset = 1'b1;
        step();
        chk("midrst_stays_idle", scrub_busy, 0);
        scrub_start = 1'b1;
        step();
        scrub_start = 1'b0;
        step();
        chk("midrst_restart_we",  ctrl_writeEnable, 1);
        chk("midrst_restart_reg", ctrl_writeReg,    1);
        for (int i = 0; i < 32; i++) step();

        // random mix, scoreboard only
        verbose = 1'b0;
        for (int i = 0; i < 600; i++) begin
            cpu_we   = ($urandom_range(3) == 0);
            cpu_reg  = 5'($urandom_range(31));
            cpu_data = $urandom;
            scrub_start = ($urandom_range(24) == 0);
            ctrl_reset  = ($urandom_range(80) != 0);
            if (io_ack) begin
                // sometimes keep io_req high with a fresh request
                io_req = ($urandom_range(1) == 1);
                io_reg = 5'($urandom_range(31));
                io_data = $urandom;
            end else if (!io_req && $urandom_range(2) == 0) begin
                io_req  = 1'b1;
                io_reg  = 5'($urandom_range(31));
                io_data = $urandom;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
